uart_rx_cfg: RTL and testbench

//  Parametrised UART receiver, successor of the fixed 8N1-style RX. Oversamples a 2-FF

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_rx_cfg_if.sv | 21 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_rx_cfg.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver and its future transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_e;

    localparam int unsigned MAX_DATA_N_BIT = 9;

    // Parity bit the transmitter should have sent for this data word.
    function automatic logic par_calc(input logic [MAX_DATA_N_BIT-1:0] data,
                                      input parity_mode_e              mode);
        case (mode)
            PAR_EVEN: par_calc = ^data;
            PAR_ODD:  par_calc = ~^data;
            default:  par_calc = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-side output port: one data word plus status, valid/ready handshake.
interface uart_rx_cfg_if #(
    parameter int unsigned DATA_N_BIT = 8
);
    logic [DATA_N_BIT-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  parity_error;
    logic                  frame_error;
    logic                  overrun;

    modport master (
        output dout, dout_valid, parity_error, frame_error, overrun,
        input  dout_ready
    );

    modport slave (
        input  dout, dout_valid, parity_error, frame_error, overrun,
        output dout_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running 1-in-DIV tick generator with a restart that realigns the phase to a line edge.
module uart_baud_tick #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic sync_rst,
    input  logic restart,
    output logic tick
);
    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    if (DIV < 1) begin : g_div_check
        $error("uart_baud_tick: DIV must be at least 1");
    end

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = !restart && (cnt_q == CntLast);
        cnt_d = cnt_q + 1'b1;
        if (restart || cnt_q == CntLast) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver: 5..9 data bits, none/even/odd parity, 1/2 stop bits,
// majority-voted bits, false-start rejection and a valid/ready output register.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned  DATA_N_BIT  = 8,
    parameter parity_mode_e PARITY_MODE = PAR_EVEN,
    parameter int unsigned  STOP_N_BIT  = 1,
    parameter int unsigned  F_CLK_Hz    = 100_000_000,
    parameter int unsigned  BAUD_RATE   = 115_200,
    parameter int unsigned  OVERSAMPLE  = 16
) (
    input  logic          clk,
    input  logic          sync_rst,
    input  logic          uart_din,
    output logic          busy,
    uart_rx_cfg_if.master rx_if
);
    localparam int TICK_DIV = int'(F_CLK_Hz / (BAUD_RATE * OVERSAMPLE));
    localparam int unsigned SampW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_N_BIT);
    localparam logic [SampW-1:0] VoteLo   = SampW'(OVERSAMPLE / 2 - 1);
    localparam logic [SampW-1:0] VoteMid  = SampW'(OVERSAMPLE / 2);
    localparam logic [SampW-1:0] VoteHi   = SampW'(OVERSAMPLE / 2 + 1);
    localparam logic [SampW-1:0] SampLast = SampW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_N_BIT - 1);

    if (DATA_N_BIT < 5 || DATA_N_BIT > MAX_DATA_N_BIT) begin : g_data_check
        $error("uart_rx_cfg: DATA_N_BIT must be 5..9");
    end
    if (STOP_N_BIT < 1 || STOP_N_BIT > 2) begin : g_stop_check
        $error("uart_rx_cfg: STOP_N_BIT must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_check
        $error("uart_rx_cfg: OVERSAMPLE must be even and >= 8");
    end

    logic                  sync1_q, sync2_q;
    rx_state_e             state_q, state_d;
    logic [SampW-1:0]      samp_q, samp_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic                  stop_q, stop_d;
    logic [DATA_N_BIT-1:0] data_q, data_d;
    logic                  s0_q, s0_d, s1_q, s1_d;
    logic                  perr_q, perr_d, ferr_q, ferr_d;
    logic [DATA_N_BIT-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d, operr_q, operr_d, oferr_q, oferr_d;
    logic                  ovr_q, ovr_d;

    logic din_s, tick, restart, complete, vote, vote_pt, at_end, last_stop;

    assign din_s = sync2_q;

    uart_baud_tick #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk      (clk),
        .sync_rst (sync_rst),
        .restart  (restart),
        .tick     (tick)
    );

    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        data_d    = data_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        restart   = 1'b0;
        complete  = 1'b0;
        vote      = (s0_q & s1_q) | (s0_q & din_s) | (s1_q & din_s);
        vote_pt   = tick && (samp_q == VoteHi);
        at_end    = tick && (samp_q == SampLast);
        last_stop = (STOP_N_BIT == 1) || stop_q;

        if (tick) begin
            samp_d = at_end ? '0 : samp_q + 1'b1;
        end
        if (tick && samp_q == VoteLo) s0_d = din_s;
        if (tick && samp_q == VoteMid) s1_d = din_s;

        unique case (state_q)
            IDLE: begin
                samp_d = '0;
                if (!din_s) begin
                    state_d = START;
                    restart = 1'b1;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            START: begin
                if (vote_pt && vote) state_d = IDLE;
                else if (at_end)     state_d = DATA;
            end
            DATA: begin
                if (vote_pt) data_d = {vote, data_q[DATA_N_BIT-1:1]};
                if (at_end) begin
                    if (bit_q == BitLast) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (vote_pt) perr_d = vote ^ par_calc(MAX_DATA_N_BIT'(data_q), PARITY_MODE);
                if (at_end) state_d = STOP;
            end
            STOP: begin
                // Finish at the last stop vote point so a following start bit is not missed.
                if (vote_pt) begin
                    if (!vote) ferr_d = 1'b1;
                    if (last_stop) begin
                        complete = 1'b1;
                        state_d  = (ferr_q || !vote) ? BREAK : IDLE;
                    end
                end else if (at_end) begin
                    stop_d = 1'b1;
                end
            end
            BREAK: begin
                samp_d = '0;
                if (din_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        operr_d = operr_q;
        oferr_d = oferr_q;
        ovr_d   = 1'b0;
        if (complete) begin
            if (!valid_q || rx_if.dout_ready) begin
                dout_d  = data_q;
                valid_d = 1'b1;
                operr_d = perr_q;
                oferr_d = ferr_d;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_if.dout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            samp_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            data_q  <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            operr_q <= 1'b0;
            oferr_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= uart_din;
            sync2_q <= sync1_q;
            state_q <= state_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            operr_q <= operr_d;
            oferr_q <= oferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy               = (state_q != IDLE);
    assign rx_if.dout         = dout_q;
    assign rx_if.dout_valid   = valid_q;
    assign rx_if.parity_error = operr_q;
    assign rx_if.frame_error  = oferr_q;
    assign rx_if.overrun      = ovr_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four configurations (8E1, 8O1, 8N2, 7N1), 160 clk per bit.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int BitClk = 160;

    logic       clk = 1'b0;
    logic       sync_rst = 1'b1;
    logic [3:0] din = 4'hF;
    logic [3:0] busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_N_BIT(8)) if_8e1 ();
    uart_rx_cfg_if #(.DATA_N_BIT(8)) if_8o1 ();
    uart_rx_cfg_if #(.DATA_N_BIT(8)) if_8n2 ();
    uart_rx_cfg_if #(.DATA_N_BIT(7)) if_7n1 ();

    uart_rx_cfg #(.DATA_N_BIT(8), .PARITY_MODE(PAR_EVEN), .STOP_N_BIT(1), .F_CLK_Hz(1_600_000),
                  .BAUD_RATE(10_000), .OVERSAMPLE(16))
        u_8e1 (.clk(clk), .sync_rst(sync_rst), .uart_din(din[0]), .busy(busy[0]), .rx_if(if_8e1));
    uart_rx_cfg #(.DATA_N_BIT(8), .PARITY_MODE(PAR_ODD), .STOP_N_BIT(1), .F_CLK_Hz(1_600_000),
                  .BAUD_RATE(10_000), .OVERSAMPLE(16))
        u_8o1 (.clk(clk), .sync_rst(sync_rst), .uart_din(din[1]), .busy(busy[1]), .rx_if(if_8o1));
    uart_rx_cfg #(.DATA_N_BIT(8), .PARITY_MODE(PAR_NONE), .STOP_N_BIT(2), .F_CLK_Hz(1_600_000),
                  .BAUD_RATE(10_000), .OVERSAMPLE(16))
        u_8n2 (.clk(clk), .sync_rst(sync_rst), .uart_din(din[2]), .busy(busy[2]), .rx_if(if_8n2));
    uart_rx_cfg #(.DATA_N_BIT(7), .PARITY_MODE(PAR_NONE), .STOP_N_BIT(1), .F_CLK_Hz(1_600_000),
                  .BAUD_RATE(10_000), .OVERSAMPLE(16))
        u_7n1 (.clk(clk), .sync_rst(sync_rst), .uart_din(din[3]), .busy(busy[3]), .rx_if(if_7n1));

    // Per-line record of accepted words and overrun pulses.
    int         cap_cnt[4];
    logic [8:0] cap_data[4];
    logic       cap_perr[4];
    logic       cap_ferr[4];
    int         ovr_cnt[4];

    initial begin
        for (int i = 0; i < 4; i++) begin
            cap_cnt[i] = 0; ovr_cnt[i] = 0; cap_data[i] = '0; cap_perr[i] = 0; cap_ferr[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (if_8e1.dout_valid && if_8e1.dout_ready) begin
            cap_cnt[0] <= cap_cnt[0] + 1; cap_data[0] <= 9'(if_8e1.dout);
            cap_perr[0] <= if_8e1.parity_error; cap_ferr[0] <= if_8e1.frame_error;
        end
        if (if_8o1.dout_valid && if_8o1.dout_ready) begin
            cap_cnt[1] <= cap_cnt[1] + 1; cap_data[1] <= 9'(if_8o1.dout);
            cap_perr[1] <= if_8o1.parity_error; cap_ferr[1] <= if_8o1.frame_error;
        end
        if (if_8n2.dout_valid && if_8n2.dout_ready) begin
            cap_cnt[2] <= cap_cnt[2] + 1; cap_data[2] <= 9'(if_8n2.dout);
            cap_perr[2] <= if_8n2.parity_error; cap_ferr[2] <= if_8n2.frame_error;
        end
        if (if_7n1.dout_valid && if_7n1.dout_ready) begin
            cap_cnt[3] <= cap_cnt[3] + 1; cap_data[3] <= 9'(if_7n1.dout);
            cap_perr[3] <= if_7n1.parity_error; cap_ferr[3] <= if_7n1.frame_error;
        end
        if (if_8e1.overrun) ovr_cnt[0] <= ovr_cnt[0] + 1;
        if (if_8o1.overrun) ovr_cnt[1] <= ovr_cnt[1] + 1;
        if (if_8n2.overrun) ovr_cnt[2] <= ovr_cnt[2] + 1;
        if (if_7n1.overrun) ovr_cnt[3] <= ovr_cnt[3] + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives bits LSB first, one bit time each; the last level is left on the line.
    task automatic send(input int ln, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            din[ln] = bits[i];
            wait_clk(BitClk);
        end
    endtask

    typedef struct {
        int          ln;
        logic [15:0] bits;
        int          nbits;
        logic [8:0]  exp_data;
        logic        exp_perr;
        logic        exp_ferr;
    } vec_t;

    vec_t vecs[9];
    int   c0;

    initial begin
        // Frame bits are {stop.., parity, data, start}.
        vecs[0] = '{0, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{0, 16'({1'b1, 1'b0, 8'h00, 1'b0}), 11, 9'h000, 1'b0, 1'b0};
        vecs[2] = '{0, 16'({1'b1, 1'b1, 8'h01, 1'b0}), 11, 9'h001, 1'b0, 1'b0};
        vecs[3] = '{0, 16'({1'b1, 1'b1, 8'hFF, 1'b0}), 11, 9'h0FF, 1'b1, 1'b0};
        vecs[4] = '{1, 16'({1'b1, 1'b0, 8'h3C, 1'b0}), 11, 9'h03C, 1'b1, 1'b0};
        vecs[5] = '{1, 16'({1'b1, 1'b1, 8'h3C, 1'b0}), 11, 9'h03C, 1'b0, 1'b0};
        vecs[6] = '{1, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 9'h007, 1'b0, 1'b0};
        vecs[7] = '{3, 16'({1'b1, 7'h2A, 1'b0}), 9, 9'h02A, 1'b0, 1'b0};
        vecs[8] = '{2, 16'({1'b1, 1'b1, 8'hC3, 1'b0}), 11, 9'h0C3, 1'b0, 1'b0};

        if_8e1.dout_ready = 1'b1;
        if_8o1.dout_ready = 1'b1;
        if_8n2.dout_ready = 1'b1;
        if_7n1.dout_ready = 1'b1;
        wait_clk(5);
        sync_rst = 1'b0;
        wait_clk(2);

        chk("rst_valid", 32'(if_8e1.dout_valid), 0);
        chk("rst_dout", 32'(if_8e1.dout), 0);
        chk("rst_perr", 32'(if_8e1.parity_error), 0);
        chk("rst_ferr", 32'(if_8e1.frame_error), 0);
        chk("rst_ovr", 32'(if_8e1.overrun), 0);
        chk("rst_busy", 32'(busy), 0);

        for (int v = 0; v < 9; v++) begin
            wait_clk(2 * BitClk);
            c0 = cap_cnt[vecs[v].ln];
            send(vecs[v].ln, vecs[v].bits, vecs[v].nbits);
            din[vecs[v].ln] = 1'b1;
            wait_clk(20);
            chk($sformatf("v%0d_count", v), 32'(cap_cnt[vecs[v].ln]), 32'(c0 + 1));
            chk($sformatf("v%0d_dout", v), 32'(cap_data[vecs[v].ln]), 32'(vecs[v].exp_data));
            chk($sformatf("v%0d_perr", v), 32'(cap_perr[vecs[v].ln]), 32'(vecs[v].exp_perr));
            chk($sformatf("v%0d_ferr", v), 32'(cap_ferr[vecs[v].ln]), 32'(vecs[v].exp_ferr));
        end

        // 40-clk low glitch: start rejected, nothing reported.
        wait_clk(2 * BitClk);
        c0 = cap_cnt[0];
        din[0] = 1'b0;
        wait_clk(40);
        din[0] = 1'b1;
        chk("glitch_busy_hi", 32'(busy[0]), 1);
        wait_clk(130);
        chk("glitch_busy_lo", 32'(busy[0]), 0);
        chk("glitch_no_word", 32'(cap_cnt[0]), 32'(c0));

        // 8N2: second stop bit low, line then held low three more bit times.
        wait_clk(2 * BitClk);
        c0 = cap_cnt[2];
        send(2, 16'({1'b0, 1'b1, 8'h55, 1'b0}), 11);
        wait_clk(BitClk + BitClk / 2);
        chk("brk_busy", 32'(busy[2]), 1);
        wait_clk(BitClk + BitClk / 2);
        din[2] = 1'b1;
        wait_clk(2 * BitClk);
        chk("brk_count", 32'(cap_cnt[2]), 32'(c0 + 1));
        chk("brk_dout", 32'(cap_data[2]), 32'h55);
        chk("brk_ferr", 32'(cap_ferr[2]), 1);
        chk("brk_idle", 32'(busy[2]), 0);
        send(2, 16'({1'b1, 1'b1, 8'h12, 1'b0}), 11);
        din[2] = 1'b1;
        wait_clk(20);
        chk("brk_next_count", 32'(cap_cnt[2]), 32'(c0 + 2));
        chk("brk_next_dout", 32'(cap_data[2]), 32'h12);
        chk("brk_next_ferr", 32'(cap_ferr[2]), 0);

        // Overrun: consumer stalled across two frames.
        wait_clk(2 * BitClk);
        c0 = cap_cnt[0];
        if_8e1.dout_ready = 1'b0;
        send(0, 16'({1'b1, 1'b0, 8'h11, 1'b0}), 11);
        send(0, 16'({1'b1, 1'b0, 8'h22, 1'b0}), 11);
        din[0] = 1'b1;
        wait_clk(20);
        chk("ovr_valid", 32'(if_8e1.dout_valid), 1);
        chk("ovr_dout_held", 32'(if_8e1.dout), 32'h11);
        chk("ovr_pulses", 32'(ovr_cnt[0]), 1);
        chk("ovr_no_accept", 32'(cap_cnt[0]), 32'(c0));
        @(posedge clk);
        #1 if_8e1.dout_ready = 1'b1;
        wait_clk(2);
        chk("ovr_cleared", 32'(if_8e1.dout_valid), 0);
        chk("ovr_accept", 32'(cap_cnt[0]), 32'(c0 + 1));
        chk("ovr_accept_dout", 32'(cap_data[0]), 32'h11);

        // 7N1 back-to-back, then reset in the middle of the second frame.
        wait_clk(2 * BitClk);
        c0 = cap_cnt[3];
        send(3, 16'({1'b1, 7'h7F, 1'b0}), 9);
        chk("b2b_count", 32'(cap_cnt[3]), 32'(c0 + 1));
        chk("b2b_dout", 32'(cap_data[3]), 32'h7F);
        din[3] = 1'b0;
        wait_clk(BitClk);
        din[3] = 1'b1;
        wait_clk(BitClk / 2);
        chk("b2b_second_busy", 32'(busy[3]), 1);
        sync_rst = 1'b1;
        wait_clk(2);
        chk("mrst_dout", 32'(if_7n1.dout), 0);
        chk("mrst_valid", 32'(if_7n1.dout_valid), 0);
        chk("mrst_flags", 32'({if_7n1.parity_error, if_7n1.frame_error, if_7n1.overrun}), 0);
        chk("mrst_busy", 32'(busy[3]), 0);
        sync_rst = 1'b0;
        wait_clk(2 * BitClk);
        chk("mrst_idle", 32'(busy[3]), 0);
        chk("mrst_no_word", 32'(cap_cnt[3]), 32'(c0 + 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
